// File: rtl/gpr_wr_arb_if.sv
// Request, scoreboard and register-file write bundle for gpr_wr_arb.
// The dbg_* members exist only when GPR_ARB_DBG_EN is defined.
interface gpr_wr_arb_if;
   logic        wb_vld;
   logic        wb_rdy;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;

   logic        ld_issue;
   logic [4:0]  ld_issue_addr;
   logic        ld_vld;
   logic        ld_rdy;
   logic [4:0]  ld_addr;
   logic [31:0] ld_data;

`ifdef GPR_ARB_DBG_EN
   logic        dbg_vld;
   logic        dbg_rdy;
   logic [4:0]  dbg_addr;
   logic [31:0] dbg_data;
`endif

   logic [4:0]  chk_addr_0;
   logic [4:0]  chk_addr_1;
   logic        pend_0;
   logic        pend_1;

   logic        gpr_we_;
   logic [4:0]  gpr_wr_addr;
   logic [31:0] gpr_wr_data;

   // Requesters and the register file sit on the master side.
   modport master (
      output wb_vld, wb_addr, wb_data,
      output ld_issue, ld_issue_addr, ld_vld, ld_addr, ld_data,
`ifdef GPR_ARB_DBG_EN
      output dbg_vld, dbg_addr, dbg_data,
      input  dbg_rdy,
`endif
      output chk_addr_0, chk_addr_1,
      input  wb_rdy, ld_rdy, pend_0, pend_1,
      input  gpr_we_, gpr_wr_addr, gpr_wr_data
   );

   modport slave (
      input  wb_vld, wb_addr, wb_data,
      input  ld_issue, ld_issue_addr, ld_vld, ld_addr, ld_data,
`ifdef GPR_ARB_DBG_EN
      input  dbg_vld, dbg_addr, dbg_data,
      output dbg_rdy,
`endif
      input  chk_addr_0, chk_addr_1,
      output wb_rdy, ld_rdy, pend_0, pend_1,
      output gpr_we_, gpr_wr_addr, gpr_wr_data
   );
endinterface

// File: rtl/gpr_wr_arb.sv
// GPR write-port arbiter (wb > ld, starvation-protected) with pending-load scoreboard.
// Define GPR_ARB_DBG_EN to add a debug write port sharing the ld slot by round-robin.
module gpr_wr_arb #(
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic         clk,
   input  logic         rst,
   gpr_wr_arb_if.slave  bus
);
   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   logic [3:0]  starve_q, starve_d;
   logic [31:0] pending_q, pending_d;
   logic        we_n_q, we_n_d;
   logic [4:0]  wr_addr_q, wr_addr_d;
   logic [31:0] wr_data_q, wr_data_d;

   logic        low_vld, low_is_dbg, force_low;
   logic        wb_gnt, low_gnt, ld_gnt;
`ifdef GPR_ARB_DBG_EN
   logic        rr_q, rr_d;      // 0: ld due next, 1: dbg due next
   logic        dbg_gnt;
`endif

   // Grant: wb wins unless the lower slot has waited STARVE_MAX cycles.
   always_comb begin
`ifdef GPR_ARB_DBG_EN
      low_vld    = bus.ld_vld || bus.dbg_vld;
      low_is_dbg = bus.dbg_vld && (!bus.ld_vld || rr_q);
`else
      low_vld    = bus.ld_vld;
      low_is_dbg = 1'b0;
`endif
      force_low = low_vld && (starve_q == STARVE_LIM);
      wb_gnt    = !rst && bus.wb_vld && !force_low;
      low_gnt   = !rst && low_vld && !wb_gnt;
      ld_gnt    = low_gnt && !low_is_dbg;
`ifdef GPR_ARB_DBG_EN
      dbg_gnt   = low_gnt && low_is_dbg;
`endif
   end

   always_comb begin
      // NOTE: every signal gets a default before any branch, so no latch is inferred.
      starve_d  = 4'd0;
      pending_d = pending_q;
      we_n_d    = 1'b1;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
`ifdef GPR_ARB_DBG_EN
      rr_d      = rr_q;
      if (low_gnt) rr_d = !low_is_dbg;
`endif

      if (low_vld && !low_gnt) starve_d = starve_q + 4'd1;

      // Clear first, then set, so a same-cycle reissue keeps the entry pending.
      if (ld_gnt)       pending_d[bus.ld_addr]       = 1'b0;
      if (bus.ld_issue) pending_d[bus.ld_issue_addr] = 1'b1;

      if (wb_gnt) begin
         we_n_d    = 1'b0;
         wr_addr_d = bus.wb_addr;
         wr_data_d = bus.wb_data;
      end else if (ld_gnt) begin
         we_n_d    = 1'b0;
         wr_addr_d = bus.ld_addr;
         wr_data_d = bus.ld_data;
      end
`ifdef GPR_ARB_DBG_EN
      else if (dbg_gnt) begin
         we_n_d    = 1'b0;
         wr_addr_d = bus.dbg_addr;
         wr_data_d = bus.dbg_data;
      end
`endif
   end

   // NOTE: sequential state uses non-blocking assignments only; comb logic above uses blocking.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_q  <= 4'd0;
         pending_q <= 32'd0;
         we_n_q    <= 1'b1;
         wr_addr_q <= 5'd0;
         wr_data_q <= 32'd0;
`ifdef GPR_ARB_DBG_EN
         rr_q      <= 1'b0;
`endif
      end else begin
         starve_q  <= starve_d;
         pending_q <= pending_d;
         we_n_q    <= we_n_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
`ifdef GPR_ARB_DBG_EN
         rr_q      <= rr_d;
`endif
      end
   end

   assign bus.wb_rdy      = wb_gnt;
   assign bus.ld_rdy      = ld_gnt;
`ifdef GPR_ARB_DBG_EN
   assign bus.dbg_rdy     = dbg_gnt;
`endif
   assign bus.pend_0      = pending_q[bus.chk_addr_0];
   assign bus.pend_1      = pending_q[bus.chk_addr_1];
   assign bus.gpr_we_     = we_n_q;
   assign bus.gpr_wr_addr = wr_addr_q;
   assign bus.gpr_wr_data = wr_data_q;
endmodule

// File: tb/tb_gpr_wr_arb.sv
// Directed self-checking bench for gpr_wr_arb (STARVE_MAX = 4).
// Inputs change 1 time unit after a rising edge; outputs are checked before the next edge.
module tb_gpr_wr_arb;
   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   gpr_wr_arb_if bus ();

   gpr_wr_arb #(.STARVE_MAX(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst               = 1'b1;
      bus.wb_vld        = 1'b1;   // valid during reset must still see wb_rdy=0
      bus.wb_addr       = 5'd1;
      bus.wb_data       = 32'h1;
      bus.ld_issue      = 1'b0;
      bus.ld_issue_addr = 5'd0;
      bus.ld_vld        = 1'b0;
      bus.ld_addr       = 5'd0;
      bus.ld_data       = 32'd0;
`ifdef GPR_ARB_DBG_EN
      bus.dbg_vld       = 1'b0;
      bus.dbg_addr      = 5'd0;
      bus.dbg_data      = 32'd0;
`endif
      bus.chk_addr_0    = 5'd9;
      bus.chk_addr_1    = 5'd10;

      #2;
      check("rst_wb_rdy",  32'(bus.wb_rdy),  32'd0);
      check("rst_we",      32'(bus.gpr_we_), 32'd1);
      check("rst_addr",    32'(bus.gpr_wr_addr), 32'd0);
      check("rst_data",    bus.gpr_wr_data, 32'd0);
      check("rst_pend_0",  32'(bus.pend_0), 32'd0);

      bus.wb_vld = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      tick();

      // Single write: grant in N, write in N+1, idle in N+2.
      bus.wb_vld  = 1'b1;
      bus.wb_addr = 5'd5;
      bus.wb_data = 32'hDEADBEEF;
      #1;
      check("single_wb_rdy", 32'(bus.wb_rdy), 32'd1);
      check("single_ld_rdy", 32'(bus.ld_rdy), 32'd0);
      tick();
      bus.wb_vld = 1'b0;
      check("single_we",   32'(bus.gpr_we_), 32'd0);
      check("single_addr", 32'(bus.gpr_wr_addr), 32'd5);
      check("single_data", bus.gpr_wr_data, 32'hDEADBEEF);
      tick();
      check("single_idle_we",   32'(bus.gpr_we_), 32'd1);
      check("single_hold_addr", 32'(bus.gpr_wr_addr), 32'd5);

      // Contention and starvation: wb wins 4 cycles, ld forced on the 5th.
      bus.wb_vld  = 1'b1;
      bus.wb_addr = 5'd3;
      bus.wb_data = 32'h0000_0033;
      bus.ld_vld  = 1'b1;
      bus.ld_addr = 5'd7;
      bus.ld_data = 32'h0000_0077;
      for (int cyc = 1; cyc <= 5; cyc++) begin
         #1;
         check($sformatf("starve_wb_rdy_c%0d", cyc), 32'(bus.wb_rdy), (cyc < 5) ? 32'd1 : 32'd0);
         check($sformatf("starve_ld_rdy_c%0d", cyc), 32'(bus.ld_rdy), (cyc == 5) ? 32'd1 : 32'd0);
         tick();
         check($sformatf("starve_wr_addr_c%0d", cyc), 32'(bus.gpr_wr_addr), (cyc < 5) ? 32'd3 : 32'd7);
         check($sformatf("starve_we_c%0d", cyc), 32'(bus.gpr_we_), 32'd0);
      end
      check("starve_ld_data", bus.gpr_wr_data, 32'h0000_0077);
      // Counter restarts from 0: a fresh ld request loses again right away.
      bus.ld_addr = 5'd8;
      bus.ld_data = 32'h0000_0088;
      #1;
      check("starve_reset_ld_rdy", 32'(bus.ld_rdy), 32'd0);
      check("starve_reset_wb_rdy", 32'(bus.wb_rdy), 32'd1);
      tick();
      bus.wb_vld = 1'b0;
      bus.ld_vld = 1'b0;
      tick();

      // Scoreboard set, visible next cycle.
      bus.ld_issue      = 1'b1;
      bus.ld_issue_addr = 5'd9;
      #1;
      check("sb_pend_before", 32'(bus.pend_0), 32'd0);
      tick();
      bus.ld_issue = 1'b0;
      check("sb_pend_set",   32'(bus.pend_0), 32'd1);
      check("sb_pend_1_off", 32'(bus.pend_1), 32'd0);

      // Return to r9: clear visible only one cycle after the grant.
      bus.ld_vld  = 1'b1;
      bus.ld_addr = 5'd9;
      bus.ld_data = 32'h0000_0099;
      #1;
      check("sb_ret_ld_rdy",   32'(bus.ld_rdy), 32'd1);
      check("sb_ret_pend_now", 32'(bus.pend_0), 32'd1);
      tick();
      bus.ld_vld = 1'b0;
      check("sb_pend_cleared", 32'(bus.pend_0), 32'd0);

      // Simultaneous issue and return to r9: set wins.
      bus.ld_issue      = 1'b1;
      bus.ld_issue_addr = 5'd9;
      tick();
      bus.ld_vld = 1'b1;
      #1;
      check("sb_sim_ld_rdy", 32'(bus.ld_rdy), 32'd1);
      tick();
      bus.ld_issue   = 1'b0;
      bus.ld_vld     = 1'b0;
      bus.chk_addr_1 = 5'd9;
      #1;
      check("sb_sim_pend_0", 32'(bus.pend_0), 32'd1);
      check("sb_sim_pend_1", 32'(bus.pend_1), 32'd1);

      // Asynchronous reset with a registered write outstanding.
      bus.wb_vld  = 1'b1;
      bus.wb_addr = 5'd12;
      bus.wb_data = 32'hCAFE_F00D;
      tick();
      bus.wb_vld = 1'b0;
      check("mid_we_before", 32'(bus.gpr_we_), 32'd0);
      rst = 1'b1;
      #1;
      check("mid_rst_we",     32'(bus.gpr_we_), 32'd1);
      check("mid_rst_addr",   32'(bus.gpr_wr_addr), 32'd0);
      check("mid_rst_data",   bus.gpr_wr_data, 32'd0);
      check("mid_rst_pend_0", 32'(bus.pend_0), 32'd0);
      check("mid_rst_pend_1", 32'(bus.pend_1), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      tick();

`ifdef GPR_ARB_DBG_EN
      // ld and dbg continuously valid, wb idle: ld, dbg, ld, dbg.
      bus.ld_vld   = 1'b1;
      bus.ld_addr  = 5'd20;
      bus.ld_data  = 32'h0000_0020;
      bus.dbg_vld  = 1'b1;
      bus.dbg_addr = 5'd21;
      bus.dbg_data = 32'h0000_0021;
      for (int i = 0; i < 4; i++) begin
         #1;
         check($sformatf("rr_ld_rdy_%0d", i),  32'(bus.ld_rdy),  (i % 2 == 0) ? 32'd1 : 32'd0);
         check($sformatf("rr_dbg_rdy_%0d", i), 32'(bus.dbg_rdy), (i % 2 == 1) ? 32'd1 : 32'd0);
         tick();
         check($sformatf("rr_wr_addr_%0d", i), 32'(bus.gpr_wr_addr), (i % 2 == 0) ? 32'd20 : 32'd21);
      end
      bus.ld_vld  = 1'b0;
      bus.dbg_vld = 1'b0;
      tick();
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
